// File: rtl/miriscv_int_pkg.sv
// rtl/miriscv_int_pkg.sv - shared types and constants for the MIRISCV interrupt controller
package miriscv_int_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IRQ  = 2'd1,
      BUSY = 2'd2,
      FIN  = 2'd3
   } int_state_e;

   localparam int MCAUSE_INT_BIT = 31;
   localparam int INT_ID_W       = 5;

   // mcause value with the interrupt flag set and the line index in the low bits
   function automatic logic [31:0] mk_mcause(input logic [INT_ID_W-1:0] id);
      logic [31:0] c;
      c                 = 32'(id);
      c[MCAUSE_INT_BIT] = 1'b1;
      return c;
   endfunction

   localparam logic [31:0] MCAUSE_RESET = 32'h8000_0000;

endpackage

// File: rtl/miriscv_int_ctrl_if.sv
// rtl/miriscv_int_ctrl_if.sv - request/ack bundle between peripherals, core and interrupt controller
interface miriscv_int_ctrl_if #(
   parameter int N_INT = 32
);

   logic [N_INT-1:0] int_req_i;
   logic [N_INT-1:0] mie_i;
   logic             int_rst_i;
   logic             int_o;
   logic [31:0]      mcause_o;
   logic [N_INT-1:0] int_fin_o;

   // controller side
   modport slave (
      input  int_req_i,
      input  mie_i,
      input  int_rst_i,
      output int_o,
      output mcause_o,
      output int_fin_o
   );

   // environment side: peripherals plus core/CSR unit
   modport master (
      output int_req_i,
      output mie_i,
      output int_rst_i,
      input  int_o,
      input  mcause_o,
      input  int_fin_o
   );

endinterface

// File: rtl/miriscv_int_prio_enc.sv
// rtl/miriscv_int_prio_enc.sv - rotating priority encoder, first set bit at or after start wins
module miriscv_int_prio_enc
   import miriscv_int_pkg::*;
#(
   parameter int N_INT = 32
) (
   input  logic [N_INT-1:0]    vec,
   input  logic [INT_ID_W-1:0] start,
   output logic                valid,
   output logic [INT_ID_W-1:0] id
);

   // index of the bit at distance off from start, wrapping at N_INT
   function automatic logic [INT_ID_W-1:0] rot_idx(input logic [INT_ID_W-1:0] s, input int off);
      int t;
      t = int'(s) + off;
      if (t >= N_INT) t = t - N_INT;
      return t[INT_ID_W-1:0];
   endfunction

   // scan from the farthest offset down so the nearest set bit to start is kept last
   always_comb begin
      valid = 1'b0;
      id    = '0;
      for (int i = N_INT - 1; i >= 0; i--) begin
         if (vec[rot_idx(start, i)]) begin
            valid = 1'b1;
            id    = rot_idx(start, i);
         end
      end
   end

endmodule

// File: rtl/miriscv_int_ctrl.sv
// rtl/miriscv_int_ctrl.sv - core-side interrupt controller; MIRISCV_INT_RR_EN selects round-robin arbitration
module miriscv_int_ctrl
   import miriscv_int_pkg::*;
#(
   parameter int N_INT = 32
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   miriscv_int_ctrl_if.slave bus
);

   int_state_e          state_q, state_d;
   logic [INT_ID_W-1:0] id_q, id_d;
   logic                int_q, int_d;
   logic [31:0]         mcause_q, mcause_d;
   logic [N_INT-1:0]    fin_q, fin_d;

   logic [N_INT-1:0]    pending;
   logic [INT_ID_W-1:0] search_start;
   logic                sel_valid;
   logic [INT_ID_W-1:0] sel_id;

   assign pending = bus.int_req_i & bus.mie_i;

`ifdef MIRISCV_INT_RR_EN
   logic [INT_ID_W-1:0] last_q;

   // search resumes one past the most recently serviced line
   always_comb begin
      search_start = last_q + 1'b1;
      if (last_q == INT_ID_W'(N_INT - 1)) search_start = '0;
   end

   // remember the serviced line once its finish pulse goes out
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         last_q <= INT_ID_W'(N_INT - 1);
      end else if (state_q == FIN) begin
         last_q <= id_q;
      end
   end
`else
   assign search_start = '0;
`endif

   miriscv_int_prio_enc #(
      .N_INT (N_INT)
   ) u_prio_enc (
      .vec   (pending),
      .start (search_start),
      .valid (sel_valid),
      .id    (sel_id)
   );

   // state and registered outputs; reset also aborts any service in flight
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         id_q     <= '0;
         int_q    <= 1'b0;
         mcause_q <= MCAUSE_RESET;
         fin_q    <= '0;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         int_q    <= int_d;
         mcause_q <= mcause_d;
         fin_q    <= fin_d;
      end
   end

   // next state plus next values of the registered outputs
   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      int_d    = 1'b0;
      mcause_d = mcause_q;
      fin_d    = '0;
      unique case (state_q)
         IDLE: begin
            if (sel_valid) begin
               id_d     = sel_id;
               mcause_d = mk_mcause(sel_id);
               int_d    = 1'b1;
               state_d  = IRQ;
            end
         end
         IRQ: begin
            if (bus.int_rst_i) begin
               fin_d        = '0;
               fin_d[id_q]  = 1'b1;
               state_d      = FIN;
            end else begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (bus.int_rst_i) begin
               fin_d        = '0;
               fin_d[id_q]  = 1'b1;
               state_d      = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.int_o     = int_q;
   assign bus.mcause_o  = mcause_q;
   assign bus.int_fin_o = fin_q;

endmodule

// File: tb/tb_miriscv_int_ctrl.sv
// tb/tb_miriscv_int_ctrl.sv - directed self-checking bench for miriscv_int_ctrl
module tb_miriscv_int_ctrl;

   localparam int N_INT = 32;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   miriscv_int_ctrl_if #(.N_INT(N_INT)) bus ();

   miriscv_int_ctrl #(.N_INT(N_INT)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.int_req_i = '0;
      bus.mie_i     = '0;
      bus.int_rst_i = 1'b0;
      step();
      step();
      tests_run++;
      if (bus.int_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_int_o: got %0b want 0", bus.int_o);
      end
      tests_run++;
      if (bus.mcause_o !== 32'h8000_0000) begin
         tests_failed++;
         $display("FAIL reset_mcause: got %h want 80000000", bus.mcause_o);
      end
      tests_run++;
      if (bus.int_fin_o !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_fin: got %h want 00000000", bus.int_fin_o);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single_line();
      bus.mie_i = 32'h0000_8000;
      step();
      bus.int_req_i = 32'h0000_8000;
      step();
      tests_run++;
      if (bus.int_o !== 1'b1 || bus.mcause_o !== 32'h8000_000F) begin
         tests_failed++;
         $display("FAIL single_irq: got int_o=%0b mcause=%h want 1 8000000f", bus.int_o, bus.mcause_o);
      end
      step();
      tests_run++;
      if (bus.int_o !== 1'b0 || bus.int_fin_o !== 32'h0) begin
         tests_failed++;
         $display("FAIL single_busy: got int_o=%0b fin=%h want 0 00000000", bus.int_o, bus.int_fin_o);
      end
      bus.int_rst_i = 1'b1;
      step();
      bus.int_rst_i = 1'b0;
      tests_run++;
      if (bus.int_fin_o !== 32'h0000_8000) begin
         tests_failed++;
         $display("FAIL single_fin: got %h want 00008000", bus.int_fin_o);
      end
      bus.int_req_i = '0;
      step();
      tests_run++;
      if (bus.int_fin_o !== 32'h0 || bus.int_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_idle: got fin=%h int_o=%0b want 00000000 0", bus.int_fin_o, bus.int_o);
      end
      tests_run++;
      if (bus.mcause_o !== 32'h8000_000F) begin
         tests_failed++;
         $display("FAIL single_mcause_hold: got %h want 8000000f", bus.mcause_o);
      end
   endtask

   task automatic test_masked();
      int bad;
      bad           = 0;
      bus.mie_i     = '0;
      bus.int_req_i = 32'hFFFF_FFFF;
      for (int c = 0; c < 50; c++) begin
         bus.int_rst_i = (c == 20);
         step();
         if (bus.int_o !== 1'b0 || bus.int_fin_o !== 32'h0) bad++;
      end
      bus.int_rst_i = 1'b0;
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL masked_quiet: got %0d active cycles want 0", bad);
      end
      bus.int_req_i = '0;
      step();
   endtask

   task automatic test_priority();
      bus.mie_i     = 32'hFFFF_FFFF;
      bus.int_req_i = 32'h0000_8008;
      step();
      tests_run++;
      if (bus.int_o !== 1'b1 || bus.mcause_o !== 32'h8000_0003) begin
         tests_failed++;
         $display("FAIL prio_first: got int_o=%0b mcause=%h want 1 80000003", bus.int_o, bus.mcause_o);
      end
      step();
      bus.int_rst_i = 1'b1;
      step();
      bus.int_rst_i = 1'b0;
      tests_run++;
      if (bus.int_fin_o !== 32'h0000_0008) begin
         tests_failed++;
         $display("FAIL prio_fin3: got %h want 00000008", bus.int_fin_o);
      end
      bus.int_req_i = 32'h0000_8000;
      step();
`ifdef MIRISCV_INT_RR_EN
      bus.int_req_i = 32'h0000_8008;
`endif
      step();
      tests_run++;
      if (bus.int_o !== 1'b1 || bus.mcause_o !== 32'h8000_000F) begin
         tests_failed++;
         $display("FAIL prio_second: got int_o=%0b mcause=%h want 1 8000000f", bus.int_o, bus.mcause_o);
      end
      bus.int_rst_i = 1'b1;
      step();
      bus.int_rst_i = 1'b0;
      tests_run++;
      if (bus.int_fin_o !== 32'h0000_8000) begin
         tests_failed++;
         $display("FAIL prio_fin15: got %h want 00008000", bus.int_fin_o);
      end
`ifdef MIRISCV_INT_RR_EN
      bus.int_req_i = 32'h0000_0008;
      step();
      step();
      tests_run++;
      if (bus.int_o !== 1'b1 || bus.mcause_o !== 32'h8000_0003) begin
         tests_failed++;
         $display("FAIL prio_rr_third: got int_o=%0b mcause=%h want 1 80000003", bus.int_o, bus.mcause_o);
      end
      bus.int_rst_i = 1'b1;
      step();
      bus.int_rst_i = 1'b0;
`endif
      bus.int_req_i = '0;
      step();
      step();
   endtask

   task automatic test_fast_ack();
      bus.mie_i     = 32'hFFFF_FFFF;
      bus.int_req_i = 32'h0000_0020;
      step();
      tests_run++;
      if (bus.int_o !== 1'b1 || bus.mcause_o !== 32'h8000_0005) begin
         tests_failed++;
         $display("FAIL fast_irq: got int_o=%0b mcause=%h want 1 80000005", bus.int_o, bus.mcause_o);
      end
      bus.int_rst_i = 1'b1;
      step();
      bus.int_rst_i = 1'b0;
      tests_run++;
      if (bus.int_fin_o !== 32'h0000_0020 || bus.int_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL fast_fin: got fin=%h int_o=%0b want 00000020 0", bus.int_fin_o, bus.int_o);
      end
      bus.int_req_i = '0;
      step();
      tests_run++;
      if (bus.int_fin_o !== 32'h0) begin
         tests_failed++;
         $display("FAIL fast_single_pulse: got %h want 00000000", bus.int_fin_o);
      end
      step();
   endtask

   task automatic test_reset_mid();
      bus.mie_i     = 32'hFFFF_FFFF;
      bus.int_req_i = 32'h0000_8000;
      step();
      step();
      tests_run++;
      if (bus.int_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid_busy: got int_o=%0b want 0", bus.int_o);
      end
      rst_n = 1'b0;
      step();
      tests_run++;
      if (bus.int_o !== 1'b0 || bus.int_fin_o !== 32'h0 || bus.mcause_o !== 32'h8000_0000) begin
         tests_failed++;
         $display("FAIL rstmid_reset: got int_o=%0b fin=%h mcause=%h want 0 00000000 80000000",
                  bus.int_o, bus.int_fin_o, bus.mcause_o);
      end
      rst_n = 1'b1;
      step();
      tests_run++;
      if (bus.int_o !== 1'b1 || bus.mcause_o !== 32'h8000_000F) begin
         tests_failed++;
         $display("FAIL rstmid_fresh: got int_o=%0b mcause=%h want 1 8000000f", bus.int_o, bus.mcause_o);
      end
      bus.int_rst_i = 1'b1;
      step();
      bus.int_rst_i = 1'b0;
      tests_run++;
      if (bus.int_fin_o !== 32'h0000_8000) begin
         tests_failed++;
         $display("FAIL rstmid_fin: got %h want 00008000", bus.int_fin_o);
      end
      bus.int_req_i = '0;
      step();
      step();
   endtask

   task automatic test_mask_change();
      bus.mie_i     = 32'hFFFF_FFFF;
      bus.int_req_i = 32'h0000_0080;
      step();
      tests_run++;
      if (bus.mcause_o !== 32'h8000_0007) begin
         tests_failed++;
         $display("FAIL mask_capture: got %h want 80000007", bus.mcause_o);
      end
      step();
      bus.mie_i = 32'hFFFF_FF7F;
      step();
      tests_run++;
      if (bus.int_o !== 1'b0 || bus.int_fin_o !== 32'h0) begin
         tests_failed++;
         $display("FAIL mask_busy: got int_o=%0b fin=%h want 0 00000000", bus.int_o, bus.int_fin_o);
      end
      bus.int_rst_i = 1'b1;
      step();
      bus.int_rst_i = 1'b0;
      tests_run++;
      if (bus.int_fin_o !== 32'h0000_0080) begin
         tests_failed++;
         $display("FAIL mask_fin: got %h want 00000080", bus.int_fin_o);
      end
      bus.int_req_i = '0;
      step();
   endtask

   initial begin
      tests_run     = 0;
      tests_failed  = 0;
      rst_n         = 1'b0;
      bus.int_req_i = '0;
      bus.mie_i     = '0;
      bus.int_rst_i = 1'b0;
      test_reset();
      test_single_line();
      test_masked();
      test_priority();
      test_fast_ack();
      test_reset_mid();
      test_mask_change();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
